sprite_line_renderer: RTL and testbench

- Parametrised successor to the fixed three-sprite VGA sprite path.
- Renders up to NUM_SPRITES sprites into ping-pong scanline buffers. The next line is prefetched from a shared sprite ROM while the current line is displayed.
- Adds colour-key transparency, index priority, right-edge clipping, frame-synchronous descriptor update and overrun detection.
- Sits between the Avalon register file (descriptor writes) and the VGA output mux.

---
 rtl/sprite_line_renderer.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_line_renderer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_renderer.sv
// Sprite scanline renderer: while one line is displayed from the front buffer,
// the next line's sprites are fetched from a shared ROM into the back buffer.
module sprite_line_renderer #(
  parameter int NUM_SPRITES = 8,
  parameter int SPR_DIM     = 32,
  parameter int ID_W        = 5,
  parameter int COLOR_W     = 24,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int ROM_LAT     = 2,
  parameter logic [COLOR_W-1:0] KEY_COLOR = '0,
  parameter logic [COLOR_W-1:0] BG_COLOR  = '0
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [9:0]                              hcount,
  input  logic [9:0]                              vcount,
  input  logic                                    line_start,
  input  logic                                    desc_we,
  input  logic [$clog2(NUM_SPRITES)-1:0]          desc_addr,
  input  logic [31:0]                             desc_wdata,
  input  logic                                    ovr_clr,
  output logic                                    rom_rd,
  output logic [ID_W+2*$clog2(SPR_DIM)-1:0]       rom_addr,
  input  logic [COLOR_W-1:0]                      rom_data,
  output logic [COLOR_W-1:0]                      pix_rgb,
  output logic                                    overrun
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(SPR_DIM);
  localparam int HW = $clog2(H_ACTIVE);
  localparam int DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [9:0]    V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    SPR_D      = 10'(SPR_DIM);
  localparam logic [9:0]    H_ACT10    = 10'(H_ACTIVE);
  localparam logic [10:0]   H_ACT11    = 11'(H_ACTIVE);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ROM_LAT - 1);
  localparam logic [IW-1:0] TOP_IDX    = IW'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic            en;
    logic [ID_W-1:0] id;
    logic [9:0]      y;
    logic [9:0]      x;
  } desc_t;

  desc_t               pend [NUM_SPRITES];
  desc_t               act  [NUM_SPRITES];
  state_t              state, state_d;
  logic [IW-1:0]       idx, idx_d;
  logic [CW-1:0]       col, col_d;
  logic [DW-1:0]       drain, drain_d;
  logic [9:0]          tgt, tgt_next;
  logic                buf_sel, back;
  logic [H_ACTIVE-1:0] mask [2];
  logic [COLOR_W-1:0]  line_buf [2][H_ACTIVE];
  logic [ROM_LAT-1:0]  pipe_v;
  logic [10:0]         pipe_px [ROM_LAT];
  desc_t               cur;
  logic [9:0]          row;
  logic                hit, last_spr, last_col, ret_wr;
  logic [10:0]         px, ret_px;
  logic                unused_bits;

  assign unused_bits = ^desc_wdata[31:26];

  assign back     = ~buf_sel;
  assign cur      = act[idx];
  assign row      = tgt - cur.y;
  assign hit      = cur.en && (tgt >= cur.y) && (row < SPR_D);
  assign last_spr = (idx == '0);
  assign last_col = (col == '1);
  assign px       = {1'b0, cur.x} + {{(11-CW){1'b0}}, col};
  assign tgt_next = (vcount == V_LAST) ? '0 : vcount + 10'd1;
  assign rom_rd   = (state == FETCH);
  assign rom_addr = rom_rd ? {cur.id, row[CW-1:0], col} : '0;
  assign ret_px   = pipe_px[ROM_LAT-1];
  assign ret_wr   = pipe_v[ROM_LAT-1] && (ret_px < H_ACT11) &&
                    (rom_data != KEY_COLOR) && !line_start;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    col_d   = col;
    drain_d = drain;
    if (line_start) begin
      idx_d   = TOP_IDX;
      col_d   = '0;
      drain_d = '0;
      state_d = (tgt_next < V_ACT) ? SCAN : IDLE;
    end else begin
      unique case (state)
        SCAN: begin
          if (hit) begin
            state_d = FETCH;
            col_d   = '0;
          end else if (last_spr) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            idx_d = idx - 1'b1;
          end
        end
        FETCH: begin
          if (!last_col) begin
            col_d = col + 1'b1;
          end else if (last_spr) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            state_d = SCAN;
            idx_d   = idx - 1'b1;
          end
        end
        DRAIN: begin
          if (drain == DRAIN_LAST) state_d = IDLE;
          else                     drain_d = drain + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      col     <= '0;
      drain   <= '0;
      tgt     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      col   <= col_d;
      drain <= drain_d;
      if (line_start) tgt <= tgt_next;
      // a fresh overrun wins over a simultaneous clear
      if (line_start && state != IDLE) overrun <= 1'b1;
      else if (ovr_clr)                overrun <= 1'b0;
    end
  end

  // Swap clears the old front's mask; in-flight returns of an aborted render are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_sel <= 1'b0;
      mask[0] <= '0;
      mask[1] <= '0;
      pipe_v  <= '0;
      for (int unsigned k = 0; k < ROM_LAT; k++) pipe_px[k] <= '0;
    end else if (line_start) begin
      buf_sel       <= back;
      mask[buf_sel] <= '0;
      pipe_v        <= '0;
    end else begin
      if (ret_wr) mask[back][ret_px[HW-1:0]] <= 1'b1;
      pipe_v[0]  <= rom_rd;
      pipe_px[0] <= px;
      for (int unsigned k = 1; k < ROM_LAT; k++) begin
        pipe_v[k]  <= pipe_v[k-1];
        pipe_px[k] <= pipe_px[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ret_wr) line_buf[back][ret_px[HW-1:0]] <= rom_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
        pend[k] <= '0;
        act[k]  <= '0;
      end
    end else begin
      if (line_start && vcount == V_ACT) act <= pend;
      if (desc_we)
        pend[desc_addr] <= {desc_wdata[25], desc_wdata[20 +: ID_W],
                            desc_wdata[19:10], desc_wdata[9:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_rgb <= '0;
    end else if (hcount < H_ACT10) begin
      pix_rgb <= mask[buf_sel][hcount[HW-1:0]] ? line_buf[buf_sel][hcount[HW-1:0]] : BG_COLOR;
    end else begin
      pix_rgb <= '0;
    end
  end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Randomized scoreboard bench for sprite_line_renderer against a per-pixel
// "topmost non-key sprite" reference model.
module tb_sprite_line_renderer;

  localparam int NS = 4, SD = 8, HA = 64, VA = 12, VT = 14, RL = 2, LINE = 80;
  localparam logic [23:0] KEY = 24'h000000;
  localparam logic [23:0] BG  = 24'hABCDEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  hcount, vcount;
  logic        line_start, desc_we, ovr_clr, rom_rd, overrun;
  logic [1:0]  desc_addr;
  logic [31:0] desc_wdata;
  logic [10:0] rom_addr;
  logic [23:0] rom_data, pix_rgb;

  always #5 clk = ~clk;

  sprite_line_renderer #(
    .NUM_SPRITES(NS), .SPR_DIM(SD), .ID_W(5), .COLOR_W(24), .H_ACTIVE(HA),
    .V_ACTIVE(VA), .V_TOTAL(VT), .ROM_LAT(RL), .KEY_COLOR(KEY), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .line_start(line_start), .desc_we(desc_we), .desc_addr(desc_addr),
    .desc_wdata(desc_wdata), .ovr_clr(ovr_clr), .rom_rd(rom_rd),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_rgb(pix_rgb), .overrun(overrun)
  );

  function automatic logic [23:0] rom_val(input int id, input int row, input int col);
    logic [10:0] a;
    a = 11'((id << 6) | (row << 3) | col);
    if (col == 5 && (id % 2) == 1) return KEY;
    return {a, a ^ 11'h5A5, 2'b01};
  endfunction

  logic [10:0] rom_pipe [RL];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr;
    for (int k = 1; k < RL; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = rom_val(int'(rom_pipe[RL-1][10:6]), int'(rom_pipe[RL-1][5:3]),
                            int'(rom_pipe[RL-1][2:0]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int p_x[NS], p_y[NS], p_id[NS], a_x[NS], a_y[NS], a_id[NS];
  bit p_en[NS], a_en[NS];
  logic [23:0] disp_img[HA], next_img[HA];
  bit disp_known, m_ovr;
  int busy_end;

  typedef struct {
    int          stamp;
    bit          chk_pix;
    logic [23:0] pix;
    bit          ovr;
    int          line;
    int          h;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0, n_pass = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  function automatic logic [23:0] exp_pixel(input int t, input int h);
    logic [23:0] v;
    for (int s = 0; s < NS; s++) begin
      if (a_en[s] && t >= a_y[s] && t - a_y[s] < SD && h >= a_x[s] && h < a_x[s] + SD) begin
        v = rom_val(a_id[s], t - a_y[s], h - a_x[s]);
        if (v != KEY) return v;
      end
    end
    return BG;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      p_en[s] = 0; a_en[s] = 0;
      p_x[s] = 0; p_y[s] = 0; p_id[s] = 0;
      a_x[s] = 0; a_y[s] = 0; a_id[s] = 0;
    end
    for (int h = 0; h < HA; h++) begin
      disp_img[h] = BG; next_img[h] = BG;
    end
    disp_known = 1; m_ovr = 0; busy_end = -1;
  endtask

  task automatic tick(input bit ls, input int vc, input int hc, input bit we,
                      input int wa, input logic [31:0] wd, input bit clr);
    exp_t e;
    int t, hits;
    bit ovr_now;
    line_start = ls; vcount = 10'(vc); hcount = 10'(hc);
    desc_we = we; desc_addr = 2'(wa); desc_wdata = wd; ovr_clr = clr;
    e.stamp = cyc; e.line = vc; e.h = hc;
    e.chk_pix = (hc >= HA) || disp_known;
    e.pix = (hc < HA) ? disp_img[hc] : 24'h0;
    ovr_now = 0;
    if (ls) begin
      if (vc == VA) begin
        a_x = p_x; a_y = p_y; a_id = p_id; a_en = p_en;
      end
      t = (vc == VT - 1) ? 0 : vc + 1;
      ovr_now = (cyc <= busy_end);
      disp_img = next_img;
      disp_known = !ovr_now;
      hits = 0;
      for (int s = 0; s < NS; s++)
        if (a_en[s] && t >= a_y[s] && t - a_y[s] < SD) hits++;
      for (int h = 0; h < HA; h++) next_img[h] = (t < VA) ? exp_pixel(t, h) : BG;
      busy_end = (t < VA) ? cyc + NS + hits * SD + RL : cyc;
    end
    if (ovr_now) m_ovr = 1;
    else if (clr) m_ovr = 0;
    if (we) begin
      p_x[wa] = int'(wd[9:0]); p_y[wa] = int'(wd[19:10]);
      p_id[wa] = int'(wd[24:20]); p_en[wa] = wd[25];
    end
    e.ovr = m_ovr;
    sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sbq.size() > 0 && sbq[0].stamp < cyc) begin
      e = sbq.pop_front();
      if (e.chk_pix) check($sformatf("pix v%0d h%0d", e.line, e.h), 32'(pix_rgb), 32'(e.pix));
      check($sformatf("overrun v%0d h%0d", e.line, e.h), 32'(overrun), 32'(e.ovr));
    end
  end

  function automatic logic [31:0] mk(input int x, input int y, input int id, input bit en);
    return {6'b0, en, 5'(id), 10'(y), 10'(x)};
  endfunction

  task automatic write_desc(input int a, input logic [31:0] d);
    tick(0, 0, 700, 1, a, d, 0);
  endtask

  int cfg_short_lo, cfg_short_hi, cfg_wline, cfg_wa, cfg_clr0, cfg_clrmid;
  logic [31:0] cfg_wd;

  task automatic cfg_none();
    cfg_short_lo = -1; cfg_short_hi = -1; cfg_wline = -1; cfg_wa = 0;
    cfg_wd = '0; cfg_clr0 = -1; cfg_clrmid = -1;
  endtask

  task automatic run_frame();
    int len;
    for (int v = 0; v < VT; v++) begin
      len = (v >= cfg_short_lo && v <= cfg_short_hi) ? 20 : LINE;
      tick(1, v, 0, v == cfg_wline, cfg_wa, cfg_wd, v == cfg_clr0);
      for (int h = 1; h < len; h++) tick(0, v, h, 0, 0, '0, (v == cfg_clrmid) && h == 10);
    end
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0;
    line_start = 0; desc_we = 0; ovr_clr = 0; hcount = '0; vcount = '0;
    desc_addr = '0; desc_wdata = '0;
    model_reset();
    cfg_none();
    repeat (3) @(posedge clk);
    #1;
    check("reset pix_rgb", 32'(pix_rgb), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);
    check("reset rom_rd", 32'(rom_rd), 32'h0);
    check("reset rom_addr", 32'(rom_addr), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    run_frame();

    write_desc(0, mk(10, 2, 3, 1));
    run_frame(); run_frame();

    // overlap with key show-through, right-edge clip, x near 1023 (no wrap)
    write_desc(0, mk(20, 4, 1, 1));
    write_desc(3, mk(20, 4, 2, 1));
    write_desc(1, mk(60, 5, 4, 1));
    write_desc(2, mk(1020, 3, 6, 1));
    run_frame(); run_frame();

    // mid-frame change, then a write coinciding with the frame copy
    cfg_wline = 5; cfg_wa = 0; cfg_wd = mk(40, 4, 1, 1);
    run_frame();
    cfg_wline = VA; cfg_wa = 1; cfg_wd = mk(0, 6, 8, 1);
    run_frame();
    cfg_none();
    run_frame(); run_frame();

    for (int s = 0; s < NS; s++) write_desc(s, mk(s * 10, 3, s, 1));
    run_frame();
    cfg_short_lo = 2; cfg_short_hi = 5; cfg_clr0 = 4; cfg_clrmid = 8;
    run_frame();
    cfg_none();
    run_frame();

    repeat (4) begin
      for (int s = 0; s < NS; s++)
        write_desc(s, {6'($urandom), 1'($urandom), 5'($urandom),
                       10'($urandom_range(0, 15)),
                       ($urandom_range(0, 4) == 0) ? 10'($urandom_range(1015, 1023))
                                                   : 10'($urandom_range(0, 70))});
      run_frame();
    end

    write_desc(0, mk(5, 3, 3, 1));
    for (int s = 1; s < NS; s++) write_desc(s, mk(0, 0, 0, 0));
    run_frame();
    tick(1, 2, 0, 0, 0, '0, 0);
    tick(1, 2, 0, 0, 0, '0, 0);
    seen = 0;
    for (int k = 1; k < 20 && !seen; k++) begin
      tick(0, 2, k, 0, 0, '0, 0);
      seen = rom_rd;
    end
    if (!seen) check("wait rom_rd before reset", 32'(rom_rd), 32'h1);
    check("overrun before reset", 32'(overrun), 32'(m_ovr));
    sbq.delete();
    reset_n = 1'b0;
    #1;
    check("async reset rom_rd", 32'(rom_rd), 32'h0);
    check("async reset pix_rgb", 32'(pix_rgb), 32'h0);
    check("async reset overrun", 32'(overrun), 32'h0);
    check("async reset rom_addr", 32'(rom_addr), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    run_frame();

    @(negedge clk); #1;
    if (sbq.size() != 0) check("scoreboard drained", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
